lcd_value_formatter: RTL and testbench

- Upstream feeder for the LCD controller.
- Accepts a binary value, converts it to decimal ASCII sequentially using shift-add-3 (double-dabble).
- Builds the two 16-character display lines and drives the controller's sendText/sendingDone handshake.
- Coalesces updates that arrive while a display write is in flight, so the most recent value is always shown.

---
 rtl/lcd_value_formatter_if.sv | 53 +++++
 rtl/lcd_value_formatter.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_lcd_value_formatter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_value_formatter_if.sv
// -----------------------------------------------------------------------------
// lcd_value_formatter_if
//
// Purpose:
//   Bundles the value-input strobe, the LCD controller sendText/sendingDone
//   handshake and the two ASCII display lines into one interface so the
//   formatter and its neighbours connect through a single port.
//
// Signals:
//   value_valid  one-cycle strobe, value is to be displayed
//   value        binary value to display (VALUE_WIDTH bits)
//   sendingDone  LCD controller reports the text write has finished
//   sendText     request to the LCD controller, level until acknowledged
//   line1        ASCII line 1, leftmost character in the top byte
//   line2        ASCII line 2, same packing
//   busy         formatter is not idle
//
// Modports:
//   master  value producer / LCD controller side (drives value and sendingDone)
//   slave   the formatter itself
// -----------------------------------------------------------------------------
interface lcd_value_formatter_if #(
  parameter int VALUE_WIDTH = 16,
  parameter int LINE_LENGTH = 16
);
  logic                     value_valid;
  logic [VALUE_WIDTH-1:0]   value;
  logic                     sendingDone;
  logic                     sendText;
  logic [8*LINE_LENGTH:1]   line1;
  logic [8*LINE_LENGTH:1]   line2;
  logic                     busy;

  modport master (
    output value_valid,
    output value,
    output sendingDone,
    input  sendText,
    input  line1,
    input  line2,
    input  busy
  );

  modport slave (
    input  value_valid,
    input  value,
    input  sendingDone,
    output sendText,
    output line1,
    output line2,
    output busy
  );
endinterface

// File: rtl/lcd_value_formatter.sv
// -----------------------------------------------------------------------------
// lcd_value_formatter
//
// Purpose:
//   Upstream feeder for the LCD controller. A binary value is converted to
//   decimal one bit per clock with shift-add-3 (double-dabble), laid out
//   right-justified on line 2 with leading-zero blanking, and handed to the
//   controller through the sendText/sendingDone handshake. Values arriving
//   while a conversion or write is in flight are coalesced into a single
//   pending slot (last value wins) so the newest value is always shown.
//
// Ports:
//   CLK    clock, all logic on the rising edge
//   RESET  synchronous active-high reset
//   bus    lcd_value_formatter_if.slave:
//            in : value_valid, value, sendingDone
//            out: sendText, line1, line2, busy (all registered)
//
// Configuration:
//   LCD_FMT_SIGNED_EN  when defined, value is two's complement; negative
//                      values show their magnitude with a '-' directly left
//                      of the most significant printed digit.
//
// Parameters:
//   VALUE_WIDTH  input value width
//   DIGITS       decimal digits produced; 10**DIGITS must exceed
//                2**VALUE_WIDTH (not checked here), DIGITS <= 15
//                (<= 14 with the signed build, to leave room for '-')
//   LINE_LENGTH  characters per line
//   LINE1_TEXT   fixed banner shown on line 1
// -----------------------------------------------------------------------------
module lcd_value_formatter #(
  parameter int                     VALUE_WIDTH = 16,
  parameter int                     DIGITS      = 5,
  parameter int                     LINE_LENGTH = 16,
  parameter logic [8*LINE_LENGTH:1] LINE1_TEXT  = "VALUE:          "
) (
  input logic                  CLK,
  input logic                  RESET,
  lcd_value_formatter_if.slave bus
);

`ifdef LCD_FMT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int BCD_W  = 4 * DIGITS;
  localparam int LINE_W = 8 * LINE_LENGTH;
  localparam int CNT_W  = $clog2(VALUE_WIDTH + 1);

  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(VALUE_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [LINE_W-1:0] BLANK_LINE = {LINE_LENGTH{8'h20}};

  // Elaboration-time guard: the digit field plus an optional sign must fit.
  if ((DIGITS > 15) || (DIGITS > LINE_LENGTH - 1) || (SIGNED_EN && (DIGITS > 14))) begin : g_bad_digits
    $error("lcd_value_formatter: DIGITS too large for the configured line");
  end

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    CONVERT      = 3'd1,
    FORMAT       = 3'd2,
    SEND         = 3'd3,
    WAIT_RELEASE = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Magnitude to convert; the most negative value maps onto itself, which is
  // exactly its unsigned magnitude.
  function automatic logic [VALUE_WIDTH-1:0] magnitude(input logic [VALUE_WIDTH-1:0] v);
    if (SIGNED_EN && v[VALUE_WIDTH-1]) begin
      magnitude = ~v + {{(VALUE_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic is_negative(input logic msb);
    is_negative = SIGNED_EN & msb;
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    add3 = res;
  endfunction

  // Lay out the digits right-justified. Digit i (0 = least significant)
  // lands in byte i counted from the right end of the line. Digits above
  // the most significant non-zero one are blanked; digit 0 always prints.
  function automatic logic [LINE_W-1:0] format_line(input logic [BCD_W-1:0] bcd,
                                                    input logic             neg);
    logic [LINE_W-1:0] txt;
    int                msd;
    txt = BLANK_LINE;
    msd = 0;
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        msd = i;
      end else begin
        msd = msd;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (i <= msd) begin
        txt[8*i +: 8] = {4'h3, bcd[4*i +: 4]};
      end else begin
        txt[8*i +: 8] = 8'h20;
      end
    end
    if (neg) begin
      txt[8*(msd+1) +: 8] = 8'h2D;
    end else begin
      txt = txt;
    end
    format_line = txt;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and combinational nets
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  logic [VALUE_WIDTH-1:0] r_shift;
  logic [BCD_W-1:0]       r_bcd;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_neg;
  logic                   r_pending;
  logic [VALUE_WIDTH-1:0] r_pend_value;
  logic                   r_hold;
  logic                   r_send;
  logic                   r_busy;
  logic [LINE_W-1:0]      r_line1;
  logic [LINE_W-1:0]      r_line2;

  state_t                       w_next_state;
  logic                         w_load;
  logic [VALUE_WIDTH-1:0]       w_load_value;
  logic [BCD_W-1:0]             w_adj;
  logic [BCD_W+VALUE_WIDTH-1:0] w_shifted;

  assign w_adj     = add3(r_bcd);
  assign w_shifted = {w_adj, r_shift} << 1'b1;

  // Next-state logic; also decides when and from where a conversion starts.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_value = bus.value;
    case (r_state)
      IDLE: begin
        if (bus.value_valid) begin
          w_next_state = CONVERT;
          w_load       = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      CONVERT: begin
        if (r_cnt == CNT_ONE) begin
          w_next_state = FORMAT;
        end else begin
          w_next_state = CONVERT;
        end
      end
      FORMAT: begin
        w_next_state = SEND;
      end
      SEND: begin
        if (bus.sendingDone) begin
          w_next_state = WAIT_RELEASE;
        end else begin
          w_next_state = SEND;
        end
      end
      WAIT_RELEASE: begin
        // Complete on release, or after two consecutive high cycles so a
        // controller that never drops sendingDone cannot stall us.
        if (!bus.sendingDone || r_hold) begin
          if (bus.value_valid || r_pending) begin
            // A strobe in this very cycle is newer than the pending slot.
            w_next_state = CONVERT;
            w_load       = 1'b1;
            w_load_value = bus.value_valid ? bus.value : r_pend_value;
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_next_state = WAIT_RELEASE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Conversion datapath: load magnitude, then one shift-add-3 step per cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
    end else if (w_load) begin
      r_shift <= magnitude(w_load_value);
      r_bcd   <= '0;
      r_cnt   <= CNT_LOAD;
      r_neg   <= is_negative(w_load_value[VALUE_WIDTH-1]);
    end else if (r_state == CONVERT) begin
      r_bcd   <= w_shifted[BCD_W+VALUE_WIDTH-1:VALUE_WIDTH];
      r_shift <= w_shifted[VALUE_WIDTH-1:0];
      r_cnt   <= r_cnt - CNT_ONE;
    end
  end

  // Single-entry coalescing slot for strobes that arrive while busy.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pending    <= 1'b0;
      r_pend_value <= '0;
    end else if (w_load) begin
      r_pending    <= 1'b0;
    end else if (bus.value_valid) begin
      r_pending    <= 1'b1;
      r_pend_value <= bus.value;
    end
  end

  // Tracks whether sendingDone was already high last cycle in WAIT_RELEASE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hold <= 1'b0;
    end else if (r_state == WAIT_RELEASE) begin
      r_hold <= bus.sendingDone;
    end else begin
      r_hold <= 1'b0;
    end
  end

  // Display lines only change in FORMAT, so they are stable during the write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_line1 <= LINE1_TEXT;
      r_line2 <= BLANK_LINE;
    end else if (r_state == FORMAT) begin
      r_line1 <= LINE1_TEXT;
      r_line2 <= format_line(r_bcd, r_neg);
    end
  end

  // Registered handshake/status outputs, derived from the state being entered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_send <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_send <= (w_next_state == SEND);
      r_busy <= (w_next_state != IDLE);
    end
  end

  assign bus.sendText = r_send;
  assign bus.busy     = r_busy;
  assign bus.line1    = r_line1;
  assign bus.line2    = r_line2;

endmodule

// File: tb/tb_lcd_value_formatter.sv
// -----------------------------------------------------------------------------
// tb_lcd_value_formatter
//
// Directed bench for lcd_value_formatter. Expected line-2 text is pushed to a
// scoreboard queue whenever a value that must reach the display is strobed;
// a monitor pops and compares on every rising edge of sendText. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lcd_value_formatter;

  logic CLK;
  logic RESET;

  lcd_value_formatter_if #(.VALUE_WIDTH(16), .LINE_LENGTH(16)) bus ();

  lcd_value_formatter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int sends = 0;
  logic prev_send = 1'b0;
  logic [127:0] sb_q[$];

  localparam logic [127:0] SPACES = {16{8'h20}};
  localparam logic [127:0] BANNER = {"VALUE:", {10{8'h20}}};

  // Right-justify a short string in a 16-character field of spaces.
  function automatic logic [127:0] rj(input string s);
    logic [127:0] r;
    r = SPACES;
    for (int i = 0; i < s.len(); i++) begin
      r[8*(s.len()-1-i) +: 8] = s[i];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: each new display write must carry the next expected line.
  always @(negedge CLK) begin
    if (bus.sendText === 1'b1 && prev_send === 1'b0) begin
      sends++;
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_empty observed=unexpected_send expected=no_send");
      end
      if (sb_q.size() != 0) begin
        chk("sb_line2", bus.line2, sb_q.pop_front());
        chk("sb_line1", bus.line1, BANNER);
      end
    end
    prev_send <= bus.sendText;
  end

  task automatic strobe(input logic [15:0] v);
    bus.value       = v;
    bus.value_valid = 1'b1;
    @(negedge CLK);
    bus.value_valid = 1'b0;
  endtask

  task automatic wait_send(input string tag);
    int n;
    n = 0;
    while (bus.sendText !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, {127'd0, bus.sendText}, 128'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, {127'd0, bus.busy}, 128'd0);
  endtask

  // One-cycle acknowledge two cycles after sendText is seen high.
  task automatic ack();
    repeat (2) @(negedge CLK);
    bus.sendingDone = 1'b1;
    @(negedge CLK);
    bus.sendingDone = 1'b0;
  endtask

  task automatic show(input logic [15:0] v, input string txt, input string tag);
    sb_q.push_back(rj(txt));
    strobe(v);
    wait_send(tag);
    ack();
    wait_idle(tag);
    chk(tag, bus.line2, rj(txt));
  endtask

  initial begin
    RESET           = 1'b1;
    bus.value_valid = 1'b0;
    bus.value       = 16'd0;
    bus.sendingDone = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_send",  {127'd0, bus.sendText}, 128'd0);
    chk("rst_busy",  {127'd0, bus.busy},     128'd0);
    chk("rst_line1", bus.line1, BANNER);
    chk("rst_line2", bus.line2, SPACES);
    RESET = 1'b0;
    @(negedge CLK);

    // Latency: sendText rises exactly 18 cycles after the strobe cycle.
    sb_q.push_back(rj("12345"));
    strobe(16'd12345);
    chk("busy_conv", {127'd0, bus.busy}, 128'd1);
    repeat (16) @(negedge CLK);
    chk("send_early", {127'd0, bus.sendText}, 128'd0);
    @(negedge CLK);
    chk("send_lat", {127'd0, bus.sendText}, 128'd1);

    // Handshake: sendingDone high for 3 cycles, 3 cycles after the rise.
    repeat (3) @(negedge CLK);
    bus.sendingDone = 1'b1;
    @(negedge CLK);
    chk("hs_send_low", {127'd0, bus.sendText}, 128'd0);
    chk("hs_line2a",   bus.line2, rj("12345"));
    @(negedge CLK);
    chk("hs_line2b",   bus.line2, rj("12345"));
    @(negedge CLK);
    bus.sendingDone = 1'b0;
    @(negedge CLK);
    chk("hs_busy_low", {127'd0, bus.busy}, 128'd0);
    chk("hs_line2c",   bus.line2, rj("12345"));
    chk("hs_line1",    bus.line1, BANNER);

    // Boundary values.
    show(16'd0, "0", "val_zero");
`ifdef LCD_FMT_SIGNED_EN
    show(16'hFFFF, "-1",     "sgn_m1");
    show(16'h8000, "-32768", "sgn_min");
    show(16'h0005, "5",      "sgn_p5");
`else
    show(16'hFFFF, "65535",  "val_max");
`endif
    show(16'd9, "9", "val_nine");

    // Coalescing: 100 then 200 during SEND, only 50 and 200 get displayed.
    begin
      int s0;
      s0 = sends;
      sb_q.push_back(rj("50"));
      sb_q.push_back(rj("200"));
      strobe(16'd50);
      wait_send("co_first");
      strobe(16'd100);
      strobe(16'd200);
      chk("co_hold_line2", bus.line2, rj("50"));
      ack();
      @(negedge CLK);
      chk("co_reload_busy", {127'd0, bus.busy}, 128'd1);
      wait_send("co_second");
      ack();
      wait_idle("co_idle");
      chk("co_line2", bus.line2, rj("200"));
      chk("co_sends", 128'(sends - s0), 128'd2);
    end

    // Reset mid-CONVERT.
    strobe(16'd999);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("rc_send",  {127'd0, bus.sendText}, 128'd0);
    chk("rc_busy",  {127'd0, bus.busy},     128'd0);
    chk("rc_line2", bus.line2, SPACES);

    // Reset mid-SEND with a pending value that must be discarded.
    sb_q.push_back(rj("4321"));
    strobe(16'd4321);
    wait_send("rs_send_up");
    strobe(16'd888);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("rs_send",  {127'd0, bus.sendText}, 128'd0);
    chk("rs_busy",  {127'd0, bus.busy},     128'd0);
    chk("rs_line2", bus.line2, SPACES);
    chk("rs_line1", bus.line1, BANNER);
    repeat (25) @(negedge CLK);
    chk("rs_pend_drop", {127'd0, bus.busy}, 128'd0);

    show(16'd7, "7", "after_rst");

    repeat (3) @(negedge CLK);
    chk("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
